inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  UART program loader for instruction memory. Takes the byte stream from the receiver, reads a 32-bit word-count
//  header, packs body bytes into 32-bit instructions and writes them to consecutive addresses from 0.
//  Sits between receiver and inst_mem write port; the core is held in LOAD mode until done/error.
// PARAMETERS
//  INST_MEM_WIDTH  6   instruction address width; capacity 2**INST_MEM_WIDTH words
// PORTS
//  CLK          in   1                 system clock; all logic on posedge CLK
//  RST          in   1                 synchronous, active-high reset
//  start        in   1                 1-cycle pulse: begin a load (accepted only in IDLE/DONE/ERROR)
//  abort        in   1                 return to IDLE immediately, discard partial word
//  rx_data      in   8                 received byte
//  rx_valid     in   1                 rx_data valid this cycle (1-cycle pulse per byte)
//  inst_we      out  1                 instruction memory write strobe
//  inst_addr    out  INST_MEM_WIDTH    write address
//  inst_data    out  32                write data
//  busy         out  1                 1 in HEADER/BODY (and CHECK if enabled)
//  done         out  1                 level: load completed OK; cleared by start/abort/RST
//  error        out  1                 level: load failed; cleared by start/abort/RST
//  words_loaded out  INST_MEM_WIDTH+1  words written in current/last load
// BEHAVIOUR
//  - Reset (RST=1): state IDLE; inst_we=0, inst_addr=0, inst_data=0, busy=0, done=0, error=0, words_loaded=0.
//  - States: IDLE, HEADER, BODY, CHECK (macro only), DONE, ERROR.
//  - IDLE/DONE/ERROR --start--> HEADER; clears done, error, words_loaded, byte counter, address; rx_valid ignored.
//  - Byte order little-endian: 1st byte of any word -> [7:0], 2nd -> [15:8], 3rd -> [23:16], 4th -> [31:24].
//  - HEADER: 4 bytes form count N. After 4th byte (next cycle): N==0 -> DONE (or CHECK if macro);
//    N > 2**INST_MEM_WIDTH -> ERROR; else BODY.
//  - BODY: on 4th byte of a word, next cycle inst_we=1 for exactly 1 cycle with inst_addr=k, inst_data=word k
//    (k=0..N-1); words_loaded increments in same cycle. Latency: last rx_valid -> inst_we = 1 cycle.
//  - After write N-1: -> DONE (or CHECK). Bytes arriving back-to-back on consecutive cycles must be accepted.
//  - No address wrap: N <= capacity guaranteed by header check; inst_addr never exceeds N-1.
//  - start while busy: ignored. rx_valid in IDLE/DONE/ERROR: ignored (no write, no state change).
//  - Priority in one cycle: RST > abort > start > rx_valid. abort with rx_valid: byte dropped, no write.
//  - abort mid-word or mid-write-cycle: pending inst_we for an already-complete word still issues that cycle
//    only if registered before abort; no new strobes after abort cycle; -> IDLE, done=0, error=0.
//  - inst_addr/inst_data hold last written values when inst_we=0.
// CONFIGURATION
//  INST_LOADER_CHECKSUM_EN defined: after the body (or N==0 header) one extra byte in CHECK state = XOR of all
//    body bytes (header excluded; N==0 -> expected 0x00). Match -> DONE, mismatch -> ERROR. Words already written
//    stay in memory on mismatch. busy=1 in CHECK.
//  Not defined: no CHECK state; completion goes straight to DONE; a following byte is ignored.
// TESTING
//  1. RST, start, bytes 02 00 00 00 | 78 56 34 12 | EF BE AD DE -> writes (0,0x12345678),(1,0xDEADBEEF); done=1,
//     words_loaded=2, inst_we high exactly 2 cycles, each 1 cycle after 4th byte.
//  2. Header N=2**INST_MEM_WIDTH+1 (0x41 00 00 00 at default) -> error=1, no inst_we; then start + valid load -> done.
//  3. Header 00 00 00 00 -> done=1, words_loaded=0, no inst_we (with macro: needs byte 00; byte 01 -> error).
//  4. abort after 2 body bytes of word 1 -> IDLE, done=error=0, only word 0 written; later bytes ignored.
//  5. Back-to-back rx_valid every cycle for 64 words at default -> all 64 addresses 0..63 written in order, done=1.
//  6. Macro on: body 01 02 03 04, checksum 04 -> done; checksum 05 -> error; start during BODY ignored.

Source files
------------

// File: rtl/inst_loader.sv
// UART program loader: word-count header, little-endian body, writes inst_mem.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader #(
  parameter int INST_MEM_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      inst_we,
  output logic [INST_MEM_WIDTH-1:0] inst_addr,
  output logic [31:0]               inst_data,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [INST_MEM_WIDTH:0]   words_loaded
);

  localparam logic [32:0] CAP = 33'(1) << INST_MEM_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_BODY,
`ifdef INST_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef INST_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CHECK;
`else
  localparam state_t S_FIN = S_DONE;
`endif

  state_t                    r_state;
  state_t                    w_state_n;
  logic [1:0]                r_bcnt;
  logic [31:0]               r_shift;
  logic [INST_MEM_WIDTH:0]   r_count;
  logic [INST_MEM_WIDTH:0]   r_words;
  logic                      r_we;
  logic [INST_MEM_WIDTH-1:0] r_addr;
  logic [31:0]               r_data;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]                r_csum;
`endif

  logic        w_busy;
  logic        w_start;
  logic        w_take;
  logic        w_wend;
  logic        w_last;
  logic [31:0] w_word;

  // Decode handshakes and the completed word (new byte lands in [31:24]).
  always_comb begin
    w_busy  = (r_state == S_HEADER) || (r_state == S_BODY)
`ifdef INST_LOADER_CHECKSUM_EN
              || (r_state == S_CHECK)
`endif
              ;
    w_start = start && !w_busy && !abort;
    w_take  = rx_valid && !abort
              && ((r_state == S_HEADER) || (r_state == S_BODY));
    w_wend  = w_take && (r_bcnt == 2'd3);
    w_word  = {rx_data, r_shift[31:8]};
    w_last  = (r_words + 1'b1) == r_count;
  end

  // Next-state logic: abort > start > rx byte.
  always_comb begin
    w_state_n = r_state;
    if (abort) begin
      w_state_n = S_IDLE;
    end else if (w_start) begin
      w_state_n = S_HEADER;
    end else if (rx_valid) begin
      unique case (r_state)
        S_HEADER: begin
          if (r_bcnt == 2'd3) begin
            if (w_word == 32'd0)
              w_state_n = S_FIN;
            else if ({1'b0, w_word} > CAP)
              w_state_n = S_ERROR;
            else
              w_state_n = S_BODY;
          end
        end
        S_BODY: begin
          if (r_bcnt == 2'd3 && w_last)
            w_state_n = S_FIN;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (rx_data == r_csum)
            w_state_n = S_DONE;
          else
            w_state_n = S_ERROR;
        end
`endif
        default: ;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= S_IDLE;
    else
      r_state <= w_state_n;
  end

  // Byte assembly, write strobe and counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bcnt  <= '0;
      r_shift <= '0;
      r_count <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      if (abort) begin
        r_bcnt <= '0;
      end else if (w_start) begin
        r_bcnt  <= '0;
        r_words <= '0;
        r_addr  <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
        r_csum  <= '0;
`endif
      end else if (w_take) begin
        r_shift <= w_word;
        r_bcnt  <= r_bcnt + 2'd1;
        if (r_state == S_HEADER && w_wend)
          r_count <= w_word[INST_MEM_WIDTH:0];
        if (r_state == S_BODY) begin
`ifdef INST_LOADER_CHECKSUM_EN
          r_csum <= r_csum ^ rx_data;
`endif
          if (w_wend) begin
            r_we    <= 1'b1;
            r_addr  <= r_words[INST_MEM_WIDTH-1:0];
            r_data  <= w_word;
            r_words <= r_words + 1'b1;
          end
        end
      end
    end
  end

  assign inst_we      = r_we;
  assign inst_addr    = r_addr;
  assign inst_data    = r_data;
  assign busy         = w_busy;
  assign done         = (r_state == S_DONE);
  assign error        = (r_state == S_ERROR);
  assign words_loaded = r_words;

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes queued by stimulus,
// popped and compared by a negedge monitor.
module tb_inst_loader;
  localparam int W = 6;

  logic          CLK = 1'b0;
  logic          RST, start, abort, rx_valid;
  logic [7:0]    rx_data;
  logic          inst_we, busy, done, error;
  logic [W-1:0]  inst_addr;
  logic [31:0]   inst_data;
  logic [W:0]    words_loaded;

  inst_loader #(.INST_MEM_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_data(inst_data),
    .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [W-1:0] a;
    logic [31:0]  d;
    logic [31:0]  c;
  } wr_t;

  wr_t          q[$];
  wr_t          e;
  int           checks = 0;
  int           errors = 0;
  logic [31:0]  cyc = 0;
  logic [W-1:0] exp_addr;
  logic [7:0]   csum;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (inst_we === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", inst_addr, inst_data);
      end else begin
        e = q.pop_front();
        if (inst_addr !== e.a || inst_data !== e.d || cyc !== e.c) begin
          errors++;
          $display("FAIL write got a=%0d d=%h cyc=%0d want a=%0d d=%h cyc=%0d",
                   inst_addr, inst_data, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, a, x);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic new_load();
    pulse_start();
    exp_addr = '0;
    csum     = 8'h00;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 0; i < 4; i++) send(8'((n >> (8 * i)) & 32'hFF));
  endtask

  task automatic send_body(input logic [31:0] w);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = 8'((w >> (8 * i)) & 32'hFF);
      csum = csum ^ b;
      send(b);
    end
    q.push_back('{a: exp_addr, d: w, c: cyc});
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
    send(csum);
`endif
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    exp_addr = '0; csum = 8'h00;
    idle(3);
    chk("rst_flags", {busy, done, error, inst_we}, 4'b0000);
    chk("rst_addr", inst_addr, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_words", words_loaded, 0);
    RST = 1'b0;
    idle(1);

    // 1: two-word load, with an ignored start mid-body
    new_load();
    chk("t1_busy", busy, 1);
    send_hdr(32'd2);
    send_body(32'h12345678);
    pulse_start();
    send_body(32'hDEADBEEF);
    finish_load();
    idle(2);
    chk("t1_flags", {busy, done, error}, 3'b010);
    chk("t1_words", words_loaded, 2);
    chk("t1_hold_addr", inst_addr, 1);
    chk("t1_hold_data", inst_data, 32'hDEADBEEF);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    idle(2);
    chk("t1_done_stays", done, 1);

    // 2: oversize header, then a good load
    new_load();
    chk("t2_clear", {done, words_loaded}, 0);
    send_hdr(32'h41);
    idle(1);
    chk("t2_error", {busy, done, error}, 3'b001);
    new_load();
    chk("t2_err_clr", error, 0);
    send_hdr(32'd1);
    send_body(32'hCAFEF00D);
    finish_load();
    idle(2);
    chk("t2_done", {done, error}, 2'b10);
    chk("t2_words", words_loaded, 1);

    // 3: empty program
    new_load();
    send_hdr(32'd0);
    finish_load();
    idle(1);
    chk("t3_done", {busy, done, error}, 3'b010);
    chk("t3_words", words_loaded, 0);
`ifdef INST_LOADER_CHECKSUM_EN
    new_load();
    send_hdr(32'd0);
    send(8'h01);
    idle(1);
    chk("t3_csum_bad", {done, error}, 2'b01);
`endif

    // 4: abort mid word 1
    new_load();
    send_hdr(32'd2);
    send_body(32'h11223344);
    send(8'hAA);
    send(8'hBB);
    abort = 1'b1;
    idle(1);
    abort = 1'b0;
    chk("t4_idle", {busy, done, error}, 3'b000);
    send(8'hCC); send(8'hDD); send(8'hEE); send(8'hFF);
    idle(2);
    chk("t4_still_idle", {busy, done, error}, 3'b000);
    chk("t4_addr", inst_addr, 0);
    chk("t4_data", inst_data, 32'h11223344);

    // 5: full capacity, back-to-back bytes
    new_load();
    send_hdr(32'd64);
    for (int i = 0; i < 64; i++)
      send_body((32'h01010101 * i) ^ 32'hC0DE0000);
    finish_load();
    idle(2);
    chk("t5_done", {busy, done, error}, 3'b010);
    chk("t5_words", words_loaded, 64);
    chk("t5_addr", inst_addr, 63);

`ifdef INST_LOADER_CHECKSUM_EN
    // 6: checksum match / mismatch, start ignored in BODY
    new_load();
    send_hdr(32'd1);
    pulse_start();
    send_body(32'h04030201);
    send(8'h04);
    idle(1);
    chk("t6_match", {done, error}, 2'b10);
    new_load();
    send_hdr(32'd1);
    send_body(32'h04030201);
    send(8'h05);
    idle(1);
    chk("t6_mismatch", {done, error}, 2'b01);
`endif

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
